// File: rtl/oled_spi_monitor.sv
// oled_spi_monitor: receive-side decoder for the OLED serial link.
//
// Watches the four link wires (reset, dc, sclk, mosi) as the display driver sends
// them, rebuilds the bytes, follows the SSD1306 addressing commands and mirrors
// every display-data byte into a shadow frame-buffer write port addressed
// {page, col}, in the same format as the display RAM.
//
// Ports:
//   clk_i          system clock; must run at least 8x the sclk rate
//   rst_ni         asynchronous active-low reset
//   oled_rst_i     display reset from the link, active low
//   oled_dc_i      0 = command byte, 1 = data byte
//   oled_sclk_i    serial clock
//   oled_mosi_i    serial data, MSB first
//   byte_valid_o   one-cycle pulse per received byte
//   byte_data_o    last received byte, held until the next one
//   byte_dc_o      dc sampled with bit 0 of the byte
//   fb_wren_o      one-cycle frame-buffer write strobe
//   fb_wraddr_o    frame-buffer address {page[2:0], col[6:0]}
//   fb_wrdata_o    frame-buffer write data
//   cur_page_o     live page pointer
//   cur_col_o      live column pointer
//   frame_err_o    one-cycle pulse when a partial byte is discarded
module oled_spi_monitor #(
  parameter int unsigned SyncStages  = 2,
  parameter int unsigned IdleTimeout = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       oled_rst_i,
  input  logic       oled_dc_i,
  input  logic       oled_sclk_i,
  input  logic       oled_mosi_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_dc_o,
  output logic       fb_wren_o,
  output logic [9:0] fb_wraddr_o,
  output logic [7:0] fb_wrdata_o,
  output logic [2:0] cur_page_o,
  output logic [6:0] cur_col_o,
  output logic       frame_err_o
);

  localparam int unsigned IdleW = $clog2(IdleTimeout + 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers: {rst, dc, sclk, mosi}
  // ---------------------------------------------------------------------------
  logic [3:0] sync_q [SyncStages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SyncStages; i++) begin
        sync_q[i] <= 4'b0000;
      end
    end else begin
      sync_q[0] <= {oled_rst_i, oled_dc_i, oled_sclk_i, oled_mosi_i};
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic link_rst_n_s, dc_s, sclk_s, mosi_s;
  assign {link_rst_n_s, dc_s, sclk_s, mosi_s} = sync_q[SyncStages-1];

  logic link_rst;
  assign link_rst = ~link_rst_n_s;

  logic sclk_prev_q;
  logic sclk_rise;
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // ---------------------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------------------
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_dc_q, byte_dc_d;
  logic             fb_wren_q, fb_wren_d;
  logic [9:0]       fb_wraddr_q, fb_wraddr_d;
  logic [7:0]       fb_wrdata_q, fb_wrdata_d;
  logic             frame_err_q, frame_err_d;

  logic [2:0] page_q, page_d;
  logic [6:0] col_q, col_d;

  logic [7:0] byte_next;
  assign byte_next = {shift_q[6:0], mosi_s};

  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    fb_wren_d    = 1'b0;
    fb_wraddr_d  = fb_wraddr_q;
    fb_wrdata_d  = fb_wrdata_q;
    frame_err_d  = 1'b0;
    if (link_rst) begin
      shift_d    = '0;
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
    end else if (sclk_rise) begin
      shift_d    = byte_next;
      bit_cnt_d  = bit_cnt_q + 3'd1;  // wraps to 0 after the 8th bit
      idle_cnt_d = '0;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = byte_next;
        byte_dc_d    = dc_s;
        // The write address is the pointer before this byte's advance.
        fb_wren_d    = dc_s;
        if (dc_s) begin
          fb_wraddr_d = {page_q, col_q};
          fb_wrdata_d = byte_next;
        end
      end
    end else if (bit_cnt_q != 3'd0) begin
      if (idle_cnt_q == IdleW'(IdleTimeout - 1)) begin
        bit_cnt_d   = '0;
        idle_cnt_d  = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_prev_q  <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_dc_q    <= 1'b0;
      fb_wren_q    <= 1'b0;
      fb_wraddr_q  <= '0;
      fb_wrdata_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_s;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      fb_wren_q    <= fb_wren_d;
      fb_wraddr_q  <= fb_wraddr_d;
      fb_wrdata_q  <= fb_wrdata_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command decoder
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StArg1, StArg2} state_e;

  state_e state_q, state_d;

  logic [7:0] cmd_q, cmd_d;
  logic [7:0] arg_q, arg_d;
  logic       horiz_q, horiz_d;
  logic [6:0] col_start_q, col_start_d, col_end_q, col_end_d;
  logic [2:0] page_start_q, page_start_d, page_end_q, page_end_d;

  logic cmd_byte, data_byte;
  assign cmd_byte  = byte_valid_q & ~byte_dc_q;
  assign data_byte = byte_valid_q & byte_dc_q;

  // Commands that are followed by at least one argument byte.
  logic has_arg;
  always_comb begin
    has_arg = 1'b0;
    unique case (byte_data_q)
      8'h20, 8'h21, 8'h22,
      8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: has_arg = 1'b1;
      default: has_arg = 1'b0;
    endcase
  end

  logic two_args;
  assign two_args = (cmd_q == 8'h21) || (cmd_q == 8'h22);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (link_rst || data_byte) begin
      // A data byte abandons any pending argument.
      state_d = StIdle;
    end else if (cmd_byte) begin
      unique case (state_q)
        StIdle:  state_d = has_arg ? StArg1 : StIdle;
        StArg1:  state_d = two_args ? StArg2 : StIdle;
        StArg2:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Pointer / mode update
  always_comb begin
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    horiz_d      = horiz_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    if (link_rst) begin
      cmd_d        = '0;
      arg_d        = '0;
      horiz_d      = 1'b0;
      col_d        = '0;
      page_d       = '0;
      col_start_d  = 7'd0;
      col_end_d    = 7'd127;
      page_start_d = 3'd0;
      page_end_d   = 3'd7;
    end else if (data_byte) begin
      if (!horiz_q) begin
        col_d = col_q + 7'd1;
      end else if (col_q == col_end_q) begin
        col_d  = col_start_q;
        page_d = (page_q == page_end_q) ? page_start_q : page_q + 3'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end else if (cmd_byte) begin
      unique case (state_q)
        StIdle: begin
          cmd_d = byte_data_q;
          if (byte_data_q[7:4] == 4'h0) begin
            col_d[3:0] = byte_data_q[3:0];
          end else if (byte_data_q[7:4] == 4'h1) begin
            col_d[6:4] = byte_data_q[2:0];
          end else if (byte_data_q[7:3] == 5'b10110) begin
            page_d = byte_data_q[2:0];
          end
        end
        StArg1: begin
          arg_d = byte_data_q;
          if (cmd_q == 8'h20) begin
            horiz_d = (byte_data_q[1:0] == 2'b00);
          end
        end
        StArg2: begin
          if (cmd_q == 8'h21) begin
            col_start_d = arg_q[6:0];
            col_end_d   = byte_data_q[6:0];
            col_d       = arg_q[6:0];
          end else begin
            page_start_d = arg_q[2:0];
            page_end_d   = byte_data_q[2:0];
            page_d       = arg_q[2:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_q        <= '0;
      arg_q        <= '0;
      horiz_q      <= 1'b0;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      page_start_q <= 3'd0;
      page_end_q   <= 3'd7;
    end else begin
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      horiz_q      <= horiz_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign byte_dc_o    = byte_dc_q;
  assign fb_wren_o    = fb_wren_q;
  assign fb_wraddr_o  = fb_wraddr_q;
  assign fb_wrdata_o  = fb_wrdata_q;
  assign frame_err_o  = frame_err_q;
  assign cur_page_o   = page_q;
  assign cur_col_o    = col_q;

endmodule

// File: tb/tb_oled_spi_monitor.sv
// Directed bench for oled_spi_monitor: drives the serial link bit by bit and
// checks decoded pointers, frame-buffer writes and framing/reset behaviour.
module tb_oled_spi_monitor;

  logic       clk;
  logic       rst_n;
  logic       oled_rst;
  logic       oled_dc;
  logic       oled_sclk;
  logic       oled_mosi;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       fb_wren;
  logic [9:0] fb_wraddr;
  logic [7:0] fb_wrdata;
  logic [2:0] cur_page;
  logic [6:0] cur_col;
  logic       frame_err;

  oled_spi_monitor #(
    .SyncStages (2),
    .IdleTimeout(64)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .oled_rst_i  (oled_rst),
    .oled_dc_i   (oled_dc),
    .oled_sclk_i (oled_sclk),
    .oled_mosi_i (oled_mosi),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .byte_dc_o   (byte_dc),
    .fb_wren_o   (fb_wren),
    .fb_wraddr_o (fb_wraddr),
    .fb_wrdata_o (fb_wrdata),
    .cur_page_o  (cur_page),
    .cur_col_o   (cur_col),
    .frame_err_o (frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int bv_cnt   = 0;
  int fe_cnt   = 0;
  logic [9:0] wr_addr [$];
  logic [7:0] wr_data [$];

  // Monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) bv_cnt++;
      if (frame_err) fe_cnt++;
      if (fb_wren) begin
        wr_addr.push_back(fb_wraddr);
        wr_data.push_back(fb_wrdata);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks the write at queue position idx, guarding against a missing write.
  task automatic check_wr(input string tag, input int idx, input logic [9:0] addr,
                          input logic [7:0] data);
    if (wr_addr.size() > idx) begin
      check({tag, "_addr"}, 32'(wr_addr[idx]), 32'(addr));
      check({tag, "_data"}, 32'(wr_data[idx]), 32'(data));
    end else begin
      check({tag, "_present"}, 32'(wr_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic dc);
    @(negedge clk);
    oled_mosi = b;
    oled_dc   = dc;
    wait_clks(4);
    oled_sclk = 1'b1;
    wait_clks(4);
    oled_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
    wait_clks(6);
  endtask

  task automatic cmd(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic dat(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  int bv0, fe0;
  logic [9:0] exp_addr [5];

  initial begin
    rst_n     = 1'b0;
    oled_rst  = 1'b1;
    oled_dc   = 1'b0;
    oled_sclk = 1'b0;
    oled_mosi = 1'b0;
    wait_clks(5);

    // Reset state
    check("rst_byte_valid", 32'(byte_valid), 0);
    check("rst_byte_data", 32'(byte_data), 0);
    check("rst_fb_wren", 32'(fb_wren), 0);
    check("rst_fb_wraddr", 32'(fb_wraddr), 0);
    check("rst_ptr", 32'({cur_page, cur_col}), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    wait_clks(5);

    // Addressing commands then one data byte
    cmd(8'hB2); cmd(8'h05); cmd(8'h13);
    check("t1_page", 32'(cur_page), 2);
    check("t1_col", 32'(cur_col), 32'h35);
    dat(8'hAA);
    check_wr("t1_wr", 0, 10'h135, 8'hAA);
    check("t1_col_adv", 32'(cur_col), 32'h36);
    check("t1_byte_dc", 32'(byte_dc), 1);
    check("t1_nwr", 32'(wr_addr.size()), 1);

    // Page mode wrap at column 127
    cmd(8'hB3); cmd(8'h0F); cmd(8'h17);
    dat(8'h55);
    check_wr("t2_wr", 1, 10'h1FF, 8'h55);
    check("t2_col", 32'(cur_col), 0);
    check("t2_page", 32'(cur_page), 3);

    // Horizontal mode with column 2..3, page 6..7 window
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'h02); cmd(8'h03);
    cmd(8'h22); cmd(8'h06); cmd(8'h07);
    check("t3_col", 32'(cur_col), 2);
    check("t3_page", 32'(cur_page), 6);
    exp_addr[0] = 10'h302; exp_addr[1] = 10'h303; exp_addr[2] = 10'h382;
    exp_addr[3] = 10'h383; exp_addr[4] = 10'h302;
    for (int i = 0; i < 5; i++) dat(8'(i + 1));
    for (int i = 0; i < 5; i++) check_wr($sformatf("t3_wr%0d", i), i + 2, exp_addr[i], 8'(i + 1));

    // Contrast argument consumed; data aborts a pending argument
    cmd(8'h81); cmd(8'hB5);
    check("t4_page_kept", 32'(cur_page), 6);
    check("t4_col_kept", 32'(cur_col), 3);
    cmd(8'hA8);
    dat(8'h11);
    check_wr("t4_wr", 7, 10'h303, 8'h11);
    check("t4_ptr_adv", 32'({cur_page, cur_col}), 32'({3'd7, 7'd2}));
    cmd(8'hB1);  // decoded as a command only if the decoder is back in IDLE
    check("t4_idle_again", 32'(cur_page), 1);

    // Partial byte, idle timeout
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    wait_clks(30);
    check("t5_no_early_err", 32'(fe_cnt - fe0), 0);
    wait_clks(80);
    check("t5_frame_err", 32'(fe_cnt - fe0), 1);
    check("t5_no_byte", 32'(bv_cnt - bv0), 0);
    cmd(8'h3C);
    check("t5_byte_data", 32'(byte_data), 32'h3C);
    check("t5_byte_dc", 32'(byte_dc), 0);
    check("t5_one_byte", 32'(bv_cnt - bv0), 1);

    // Link reset mid-byte
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    @(negedge clk);
    oled_rst = 1'b0;
    wait_clks(10);
    oled_rst = 1'b1;
    wait_clks(100);
    check("t6_no_byte", 32'(bv_cnt - bv0), 0);
    check("t6_no_err", 32'(fe_cnt - fe0), 0);
    check("t6_ptr", 32'({cur_page, cur_col}), 0);
    cmd(8'h0F); cmd(8'h17);
    dat(8'h77);
    check_wr("t6_wr", 8, 10'h07F, 8'h77);
    check("t6_page_mode", 32'({cur_page, cur_col}), 0);
    check("t6_nwr", 32'(wr_addr.size()), 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
